// File: rtl/display_counter_pkg.sv
// Shared constants and helpers for the display_counter slice.
package display_counter_pkg;

  localparam int         DIGIT_W        = 4;
  localparam logic [3:0] HEX_MAX        = 4'hF;
  localparam logic [3:0] BCD_MAX        = 4'd9;
  localparam int         TICK_DIV_100MS = 5000;

  // Clamp a single digit into the decimal range 0..9.
  function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/display_counter_counter_digit.sv
// One digit of the ripple counter: computes the stepped digit and its carry/borrow.
// BCD behaviour is only built when CNT_BCD_EN is defined; otherwise the digit is hex-only.
module counter_digit
  import display_counter_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               step_en,
  input  logic               up,
  input  logic               bcd,
  output logic [DIGIT_W-1:0] next_digit,
  output logic               carry
);

`ifndef CNT_BCD_EN
  logic unused_bcd;
  assign unused_bcd = bcd;
`endif

  // Step rules for a single digit; carry means the next digit up must also step.
  always_comb begin
    next_digit = digit;
    carry      = 1'b0;
    if (step_en) begin
`ifdef CNT_BCD_EN
      if (bcd) begin
        if (up) begin
          if (digit >= BCD_MAX) begin
            next_digit = '0;
            carry      = 1'b1;
          end else begin
            next_digit = digit + 4'd1;
          end
        end else begin
          if (digit == 4'd0) begin
            next_digit = BCD_MAX;
            carry      = 1'b1;
          end else if (digit > BCD_MAX) begin
            next_digit = BCD_MAX;
          end else begin
            next_digit = digit - 4'd1;
          end
        end
      end else
`endif
      begin
        if (up) begin
          next_digit = digit + 4'd1;
          carry      = (digit == HEX_MAX);
        end else begin
          next_digit = digit - 4'd1;
          carry      = (digit == 4'd0);
        end
      end
    end
  end

endmodule

// File: rtl/display_counter.sv
// Programmable-rate N-digit hex/BCD counter feeding the four-digit display driver.
// Define CNT_BCD_EN to build the BCD mode; without it bcd_mode is ignored.
module display_counter
  import display_counter_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = TICK_DIV_100MS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      up,
  input  logic                      clr,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_val,
  input  logic                      bcd_mode,
  output logic [DIGIT_W*DIGITS-1:0] value,
  output logic                      tick,
  output logic                      wrap
);

  localparam int W  = DIGIT_W * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]   prescaler;
  logic            bcd;
  logic [DIGITS:0] carry;
  logic [W-1:0]    stepped;
  logic [W-1:0]    loaded;

`ifdef CNT_BCD_EN
  assign bcd = bcd_mode;
`else
  logic unused_bcd_mode;
  assign unused_bcd_mode = bcd_mode;
  assign bcd             = 1'b0;
`endif

  // The least significant digit always steps; each carry enables the next digit.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    counter_digit u_digit (
      .digit      (value[i*DIGIT_W +: DIGIT_W]),
      .step_en    (carry[i]),
      .up         (up),
      .bcd        (bcd),
      .next_digit (stepped[i*DIGIT_W +: DIGIT_W]),
      .carry      (carry[i+1])
    );
  end

  // Load value, with each digit clamped to 9 when counting in decimal.
  always_comb begin
    loaded = load_val;
    if (bcd) begin
      for (int i = 0; i < DIGITS; i++) begin
        loaded[i*DIGIT_W +: DIGIT_W] = sat_digit(load_val[i*DIGIT_W +: DIGIT_W]);
      end
    end
  end

  // Prescaler, count register and step pulses with clr > load > step > hold priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value     <= '0;
      prescaler <= '0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
    end else if (clr) begin
      value     <= '0;
      prescaler <= '0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
    end else if (load) begin
      value     <= loaded;
      prescaler <= '0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
    end else if (en) begin
      if (prescaler == PRE_LAST) begin
        prescaler <= '0;
        value     <= stepped;
        tick      <= 1'b1;
        wrap      <= carry[DIGITS];
      end else begin
        prescaler <= prescaler + PW'(1);
        tick      <= 1'b0;
        wrap      <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

endmodule

// File: doc/display_counter.md
Name: display_counter

Overview:
- Parametrised successor of the single-purpose 100 ms hex counter feeding four_digit_display.
- Generates a programmable-rate tick, then counts an N-digit value up or down in hex or BCD, with synchronous clear and load.
- Sits between clk/rst_n and the display driver; `value` connects directly to its `value` input.

Parameters:
- DIGITS, 4: number of 4-bit digits; value width = 4*DIGITS; legal range 1..8.
- TICK_DIV, 5000: enabled clk cycles per count step; legal range ≥1. Prescaler width is a derived localparam, clog2(TICK_DIV), minimum 1.

Ports:
- clk  in  1: clock.
- rst_n  in  1: reset.
- en  in  1: 1 = prescaler runs; 0 = prescaler and value frozen.
- up  in  1: 1 = count up, 0 = count down; sampled on each step.
- clr  in  1: synchronous clear.
- load  in  1: synchronous load of load_val.
- load_val  in  4*DIGITS: value to load.
- bcd_mode  in  1: 1 = decimal digits, 0 = hex; honoured only with CNT_BCD_EN.
- value  out  4*DIGITS: registered count.
- tick  out  1: one-cycle pulse on each count step.
- wrap  out  1: one-cycle pulse when the step rolls over the full range.

Behaviour:
- Interface: clock clk; reset rst_n, asynchronous, active-low.
- Reset values: value=0, prescaler=0, tick=0, wrap=0.
- Priority per cycle is clr > load > step > hold.
  - clr: value←0, prescaler←0, tick=0, wrap=0. Applies regardless of en.
  - load: value←load_val, prescaler←0, tick=0, wrap=0. Applies regardless of en.
- Prescaler counts 0..TICK_DIV-1 while en=1.
  - On the edge where the prescaler equals TICK_DIV-1, it returns to 0 and a step occurs.
  - The new value, tick=1 and (if applicable) wrap=1 all become visible in the same cycle.
  - TICK_DIV=1: a step occurs on every enabled cycle.
- en=0: prescaler holds its partial count; tick and wrap deassert; value holds. Resuming en continues from the held prescaler count.
- Hex step:
  - Up: value+1 modulo 2^(4*DIGITS); all-F → 0 sets wrap.
  - Down: 0 → all-F sets wrap.
- BCD step: digit-serial ripple, least significant digit first.
  - Up: a digit ≥9 becomes 0 and carries; otherwise +1.
  - Down: digit 0 becomes 9 and borrows; a digit >9 becomes 9 with no borrow (normalisation); otherwise -1.
  - wrap: all-9 → 0 (up), or all-0 → all-9 (down).
- BCD load: any load_val digit >9 is saturated to 9.
- Hex load: load_val is taken verbatim.
- bcd_mode or up changing mid-count takes effect at the next step. No other state is affected.
- tick and wrap are registered outputs and are never asserted in a clr or load cycle.

Optional Feature:
- CNT_BCD_EN defined: bcd_mode selects BCD per the rules above.
- Undefined: BCD logic is not synthesised; bcd_mode is ignored (port kept, unused); the block is hex-only.

Decomposition:
- Shared package/defines.vh:
  - DIGIT_W=4
  - HEX_MAX=4'hF
  - BCD_MAX=4'd9
  - default TICK_DIV_100MS=5000
- One sub-module: counter_digit.
  - Inputs: 4-bit digit, step-enable, up, bcd.
  - Outputs: next digit, carry/borrow out.
  - Instantiated DIGITS times in a generate chain; carry-out of digit i gates step-enable of digit i+1.

Test Plan (sim with TICK_DIV=4, DIGITS=4, CNT_BCD_EN defined):
- Reset, then en=1, up=1, hex for 40 cycles → value=0x000A; tick pulses every 4th cycle; first tick 4 cycles after en rises.
- load_val=0xFFFE, load, hex up → steps to 0xFFFF, then 0x0000 with wrap=1 for exactly one cycle, coincident with tick.
- bcd_mode=1, load 0x0999, up → 0x1000, no wrap. Load 0x9999, up → 0x0000 with wrap=1. Load 0x00A5 → value reads 0x0095.
- bcd_mode=1, down from 0x0000 → 0x9999 with wrap. Hex down from 0x0000 → 0xFFFF with wrap.
- Drop en for 10 cycles with prescaler at 2 → value and prescaler hold, tick=0. Re-enable → tick 2 cycles later.
- Assert clr and load together mid-count → value=0. Assert rst_n=0 asynchronously mid-cycle → all outputs 0 immediately, with no clock edge required.
